// File: rtl/div_rs_if.sv
// CDB packet type and the dispatch / CDB / issue bundle of the divider reservation station.
// master = pipeline side that dispatches, broadcasts and owns the divider; slave = the station.
package div_rs_pkg;
    typedef struct packed {
        logic [3:0]  dest_ROB_entry;
        logic [31:0] result;
    } CDB_packet_t;
endpackage

interface div_rs_if;
    import div_rs_pkg::*;

    logic        flush;
    logic        dispatch_valid;
    logic        dispatch_ready;
    logic        dispatch_op;
    logic [3:0]  dispatch_rob;
    logic        src1_rdy;
    logic        src2_rdy;
    logic [31:0] src1_val;
    logic [31:0] src2_val;
    logic [3:0]  src1_tag;
    logic [3:0]  src2_tag;
    logic        cdb_valid;
    CDB_packet_t cdb_in;
    logic        fu_ready;
    logic        fu_valid;
    logic [3:0]  fu_rob;
    logic        fu_op;
    logic [31:0] fu_dividend;
    logic [31:0] fu_divisor;

    modport master (
        output flush, dispatch_valid, dispatch_op, dispatch_rob,
               src1_rdy, src2_rdy, src1_val, src2_val, src1_tag, src2_tag,
               cdb_valid, cdb_in, fu_ready,
        input  dispatch_ready, fu_valid, fu_rob, fu_op, fu_dividend, fu_divisor
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_op, dispatch_rob,
               src1_rdy, src2_rdy, src1_val, src2_val, src1_tag, src2_tag,
               cdb_valid, cdb_in, fu_ready,
        output dispatch_ready, fu_valid, fu_rob, fu_op, fu_dividend, fu_divisor
    );
endinterface

// File: rtl/div_rs.sv
// Reservation station for the divider: tag-based CDB wakeup, oldest-ready issue,
// age ranks where 0 is the oldest busy entry.
module div_rs #(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    div_rs_if.slave  rs
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] op;
    logic [DEPTH-1:0] s1_rdy;
    logic [DEPTH-1:0] s2_rdy;
    logic [3:0]       rob    [DEPTH];
    logic [3:0]       s1_tag [DEPTH];
    logic [3:0]       s2_tag [DEPTH];
    logic [31:0]      s1_val [DEPTH];
    logic [31:0]      s2_val [DEPTH];
    logic [AW-1:0]    age    [DEPTH];

    logic          free_found;
    logic [AW-1:0] free_idx;
    logic          sel_found;
    logic [AW-1:0] sel_idx;
    logic [AW-1:0] sel_age;
    logic [AW-1:0] busy_cnt;
    logic          issue;
    logic          do_dispatch;
    logic          d1_rdy;
    logic          d2_rdy;
    logic [31:0]   d1_val;
    logic [31:0]   d2_val;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        busy_cnt   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
            if (busy[i]) begin
                busy_cnt = busy_cnt + AW'(1);
            end
            if (busy[i] && s1_rdy[i] && s2_rdy[i] && (!sel_found || age[i] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = age[i];
            end
        end
    end

    // reset also gates issue so entries discarded by reset never reach the divider
    assign issue       = rs.fu_ready & ~rs.flush & ~reset & sel_found;
    assign do_dispatch = rs.dispatch_valid & free_found & ~rs.flush;

    assign d1_rdy = rs.src1_rdy | (rs.cdb_valid && rs.cdb_in.dest_ROB_entry == rs.src1_tag);
    assign d2_rdy = rs.src2_rdy | (rs.cdb_valid && rs.cdb_in.dest_ROB_entry == rs.src2_tag);
    assign d1_val = rs.src1_rdy ? rs.src1_val : rs.cdb_in.result;
    assign d2_val = rs.src2_rdy ? rs.src2_val : rs.cdb_in.result;

    assign rs.dispatch_ready = free_found;
    assign rs.fu_valid       = issue;
    assign rs.fu_rob         = issue ? rob[sel_idx]    : '0;
    assign rs.fu_op          = issue ? op[sel_idx]     : 1'b0;
    assign rs.fu_dividend    = issue ? s1_val[sel_idx] : '0;
    assign rs.fu_divisor     = issue ? s2_val[sel_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            op     <= '0;
            s1_rdy <= '0;
            s2_rdy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob[i]    <= '0;
                s1_tag[i] <= '0;
                s2_tag[i] <= '0;
                s1_val[i] <= '0;
                s2_val[i] <= '0;
                age[i]    <= '0;
            end
        end else if (rs.flush) begin
            busy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                age[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy[i] && rs.cdb_valid) begin
                    if (!s1_rdy[i] && s1_tag[i] == rs.cdb_in.dest_ROB_entry) begin
                        s1_rdy[i] <= 1'b1;
                        s1_val[i] <= rs.cdb_in.result;
                    end
                    if (!s2_rdy[i] && s2_tag[i] == rs.cdb_in.dest_ROB_entry) begin
                        s2_rdy[i] <= 1'b1;
                        s2_val[i] <= rs.cdb_in.result;
                    end
                end
                // entries younger than the issued one move up one rank
                if (issue && busy[i] && age[i] > sel_age) begin
                    age[i] <= age[i] - AW'(1);
                end
            end
            if (issue) begin
                busy[sel_idx] <= 1'b0;
            end
            if (do_dispatch) begin
                busy[free_idx]   <= 1'b1;
                op[free_idx]     <= rs.dispatch_op;
                rob[free_idx]    <= rs.dispatch_rob;
                s1_rdy[free_idx] <= d1_rdy;
                s2_rdy[free_idx] <= d2_rdy;
                s1_tag[free_idx] <= rs.src1_tag;
                s2_tag[free_idx] <= rs.src2_tag;
                s1_val[free_idx] <= d1_val;
                s2_val[free_idx] <= d2_val;
                age[free_idx]    <= busy_cnt - AW'(issue);
            end
        end
    end
endmodule

// File: tb/tb_div_rs.sv
// Bench for div_rs: queue-in-dispatch-order model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_div_rs;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    div_rs_if bus ();

    div_rs #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .rs    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        op;
        logic [3:0]  rob;
        logic        r1;
        logic [3:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [3:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Model: station is a list in dispatch order; the first fully-ready entry issues.
    initial begin
        int          k;
        int          pre;
        logic        exp_valid;
        logic [3:0]  exp_rob;
        logic        exp_op;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        ent_t        e;
        forever begin
            @(negedge clk);
            #2;
            k = -1;
            if (!reset && !bus.flush && bus.fu_ready) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (k < 0 && q[i].r1 && q[i].r2) k = i;
                end
            end
            exp_valid = (k >= 0);
            exp_rob   = exp_valid ? q[k].rob : 4'd0;
            exp_op    = exp_valid ? q[k].op  : 1'b0;
            exp_a     = exp_valid ? q[k].v1  : 32'd0;
            exp_b     = exp_valid ? q[k].v2  : 32'd0;
            chk("fu_valid", {31'd0, bus.fu_valid}, {31'd0, exp_valid});
            chk("fu_rob", {28'd0, bus.fu_rob}, {28'd0, exp_rob});
            chk("fu_op", {31'd0, bus.fu_op}, {31'd0, exp_op});
            chk("fu_dividend", bus.fu_dividend, exp_a);
            chk("fu_divisor", bus.fu_divisor, exp_b);
            if (!reset) begin
                chk("dispatch_ready", {31'd0, bus.dispatch_ready}, {31'd0, q.size() < DEPTH});
            end
            if (reset || bus.flush) begin
                q.delete();
            end else begin
                pre = q.size();
                if (bus.cdb_valid) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (!q[i].r1 && q[i].t1 == bus.cdb_in.dest_ROB_entry) begin
                            q[i].r1 = 1'b1;
                            q[i].v1 = bus.cdb_in.result;
                        end
                        if (!q[i].r2 && q[i].t2 == bus.cdb_in.dest_ROB_entry) begin
                            q[i].r2 = 1'b1;
                            q[i].v2 = bus.cdb_in.result;
                        end
                    end
                end
                if (exp_valid) q.delete(k);
                if (bus.dispatch_valid && pre < DEPTH) begin
                    e.op  = bus.dispatch_op;
                    e.rob = bus.dispatch_rob;
                    e.t1  = bus.src1_tag;
                    e.t2  = bus.src2_tag;
                    e.r1  = bus.src1_rdy || (bus.cdb_valid && bus.cdb_in.dest_ROB_entry == bus.src1_tag);
                    e.r2  = bus.src2_rdy || (bus.cdb_valid && bus.cdb_in.dest_ROB_entry == bus.src2_tag);
                    e.v1  = bus.src1_rdy ? bus.src1_val : bus.cdb_in.result;
                    e.v2  = bus.src2_rdy ? bus.src2_val : bus.cdb_in.result;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic idle(input logic fr);
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_op    = 1'b0;
        bus.dispatch_rob   = 4'd0;
        bus.src1_rdy       = 1'b0;
        bus.src2_rdy       = 1'b0;
        bus.src1_val       = 32'd0;
        bus.src2_val       = 32'd0;
        bus.src1_tag       = 4'd0;
        bus.src2_tag       = 4'd0;
        bus.cdb_valid      = 1'b0;
        bus.cdb_in.dest_ROB_entry = 4'd0;
        bus.cdb_in.result  = 32'd0;
        bus.fu_ready       = fr;
    endtask

    task automatic disp(input logic o, input logic [3:0] r,
                        input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [3:0] t2);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_op    = o;
        bus.dispatch_rob   = r;
        bus.src1_rdy       = r1;
        bus.src1_val       = v1;
        bus.src1_tag       = t1;
        bus.src2_rdy       = r2;
        bus.src2_val       = v2;
        bus.src2_tag       = t2;
    endtask

    task automatic cdb(input logic [3:0] d, input logic [31:0] res);
        bus.cdb_valid             = 1'b1;
        bus.cdb_in.dest_ROB_entry = d;
        bus.cdb_in.result         = res;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle(1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(1'b1);
        #3;
        chk("rst_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        chk("rst_fu_valid", {31'd0, bus.fu_valid}, 32'd0);
        chk("rst_fu_rob", {28'd0, bus.fu_rob}, 32'd0);

        // single ready dispatch issues one cycle later
        @(negedge clk); idle(1'b1); disp(1'b1, 4'd3, 1'b1, 32'd100, 4'd0, 1'b1, 32'd7, 4'd0);
        #3; chk("t31_not_yet", {31'd0, bus.fu_valid}, 32'd0);
        @(negedge clk); idle(1'b1);
        #3;
        chk("t31_valid", {31'd0, bus.fu_valid}, 32'd1);
        chk("t31_rob", {28'd0, bus.fu_rob}, 32'd3);
        chk("t31_op", {31'd0, bus.fu_op}, 32'd1);
        chk("t31_dividend", bus.fu_dividend, 32'd100);
        chk("t31_divisor", bus.fu_divisor, 32'd7);
        @(negedge clk); idle(1'b1);
        #3; chk("t31_freed", {31'd0, bus.fu_valid}, 32'd0);

        // divisor woken by CDB three cycles after dispatch
        @(negedge clk); idle(1'b1); disp(1'b0, 4'd5, 1'b1, 32'd50, 4'd0, 1'b0, 32'd0, 4'd9);
        @(negedge clk); idle(1'b1);
        @(negedge clk); idle(1'b1);
        @(negedge clk); idle(1'b1); cdb(4'd9, 32'hFFFF_FFFB);
        #3; chk("t32_wait", {31'd0, bus.fu_valid}, 32'd0);
        @(negedge clk); idle(1'b1);
        #3;
        chk("t32_valid", {31'd0, bus.fu_valid}, 32'd1);
        chk("t32_rob", {28'd0, bus.fu_rob}, 32'd5);
        chk("t32_divisor", bus.fu_divisor, 32'hFFFF_FFFB);

        // dividend captured from CDB in the dispatch cycle
        @(negedge clk); idle(1'b1); disp(1'b1, 4'd6, 1'b0, 32'd0, 4'd2, 1'b1, 32'd5, 4'd0); cdb(4'd2, 32'd42);
        @(negedge clk); idle(1'b1);
        #3;
        chk("t33_valid", {31'd0, bus.fu_valid}, 32'd1);
        chk("t33_rob", {28'd0, bus.fu_rob}, 32'd6);
        chk("t33_dividend", bus.fu_dividend, 32'd42);

        // fill, stall, then drain in dispatch order
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk); idle(1'b0);
            disp(1'b1, 4'(r), 1'b1, 32'(r * 10), 4'd0, 1'b1, 32'(r), 4'd0);
        end
        @(negedge clk); idle(1'b0); disp(1'b1, 4'd5, 1'b1, 32'd55, 4'd0, 1'b1, 32'd5, 4'd0);
        #3; chk("t34_full", {31'd0, bus.dispatch_ready}, 32'd0);
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk); idle(1'b1);
            #3; chk("t34_order", {28'd0, bus.fu_rob}, 32'(r));
        end
        @(negedge clk); idle(1'b1);
        #3; chk("t34_empty", {31'd0, bus.fu_valid}, 32'd0);

        // flush dominates dispatch and issue
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); idle(1'b0);
            disp(1'b0, 4'(8 + r), 1'b1, 32'd9, 4'd0, 1'b1, 32'd3, 4'd0);
        end
        @(negedge clk); idle(1'b1); bus.flush = 1'b1;
        disp(1'b0, 4'd12, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        #3; chk("t35_no_issue", {31'd0, bus.fu_valid}, 32'd0);
        @(negedge clk); idle(1'b1);
        #3;
        chk("t35_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        chk("t35_empty", {31'd0, bus.fu_valid}, 32'd0);

        // younger ready entry bypasses an older waiting one
        @(negedge clk); idle(1'b0); disp(1'b0, 4'd7, 1'b1, 32'd70, 4'd0, 1'b0, 32'd0, 4'd11);
        @(negedge clk); idle(1'b0); disp(1'b0, 4'd8, 1'b1, 32'd80, 4'd0, 1'b1, 32'd4, 4'd0);
        @(negedge clk); idle(1'b1);
        #3; chk("t36_young", {28'd0, bus.fu_rob}, 32'd8);
        @(negedge clk); idle(1'b1); cdb(4'd11, 32'd3);
        #3; chk("t36_wait", {31'd0, bus.fu_valid}, 32'd0);
        @(negedge clk); idle(1'b1);
        #3;
        chk("t36_old", {28'd0, bus.fu_rob}, 32'd7);
        chk("t36_divisor", bus.fu_divisor, 32'd3);

        // reset with busy entries discards them without issue
        @(negedge clk); idle(1'b0); disp(1'b1, 4'd1, 1'b1, 32'd11, 4'd0, 1'b1, 32'd2, 4'd0);
        @(negedge clk); idle(1'b0); disp(1'b1, 4'd2, 1'b1, 32'd22, 4'd0, 1'b1, 32'd2, 4'd0);
        @(negedge clk); idle(1'b1); reset = 1'b1;
        #3; chk("t30_no_issue", {31'd0, bus.fu_valid}, 32'd0);
        @(negedge clk); idle(1'b1); reset = 1'b0;
        #3;
        chk("t30_ready", {31'd0, bus.dispatch_ready}, 32'd1);
        chk("t30_empty", {31'd0, bus.fu_valid}, 32'd0);

        // randomized traffic; small tag space so wakeups are frequent
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            idle($urandom_range(0, 9) < 7);
            reset     = ($urandom_range(0, 199) == 0);
            bus.flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6) begin
                disp(1'($urandom), 4'($urandom),
                     1'($urandom), $urandom, 4'($urandom_range(0, 3)),
                     1'($urandom), $urandom, 4'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 1) == 1) begin
                cdb(4'($urandom_range(0, 3)), $urandom);
            end
        end

        @(negedge clk);
        reset = 1'b0;
        idle(1'b0);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
